// File: rtl/rd_req_arb_if.sv
// rd_req_arb_if: requester, memory request/response and status signals of the read arbiter
interface rd_req_arb_if #(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512
);
    logic                   enable;
    logic                   req0_valid;
    logic                   req1_valid;
    logic [ADDR_LMT-1:0]    req0_addr;
    logic [ADDR_LMT-1:0]    req1_addr;
    logic                   req0_ready;
    logic                   req1_ready;
    logic [ADDR_LMT-1:0]    rd_req_addr;
    logic [MDATA-1:0]       rd_req_mdata;
    logic                   rd_req_en;
    logic                   rd_req_almostfull;
    logic                   rd_rsp_valid;
    logic [MDATA-1:0]       rd_rsp_mdata;
    logic [CACHE_WIDTH-1:0] rd_rsp_data;
    logic                   rsp0_valid;
    logic                   rsp1_valid;
    logic [CACHE_WIDTH-1:0] rsp0_data;
    logic [CACHE_WIDTH-1:0] rsp1_data;
    logic [10:0]            outstanding;
    logic                   drained;
    logic                   tag_err;
    modport master (
        input  enable, req0_valid, req1_valid, req0_addr, req1_addr,
               rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
        output req0_ready, req1_ready, rd_req_addr, rd_req_mdata, rd_req_en,
               rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, outstanding, drained, tag_err
    );
    modport slave (
        output enable, req0_valid, req1_valid, req0_addr, req1_addr,
               rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
        input  req0_ready, req1_ready, rd_req_addr, rd_req_mdata, rd_req_en,
               rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, outstanding, drained, tag_err
    );
endinterface

// File: rtl/rd_req_arb.sv
// rd_req_arb: round-robin arbiter of two read streams with tagging, response routing and drain control
module rd_req_arb #(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512,
    parameter int MAX_OUT     = 64
) (
    input  logic         clk,
    input  logic         rst,
    rd_req_arb_if.master bus
);
    typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;
    state_t           state, state_nxt;
    logic             ptr;
    logic [MDATA-2:0] seq0, seq1;
    logic             grant_ok, xfer0, xfer1, xfer, dec;
    logic [10:0]      out_nxt;
    always_comb begin
        grant_ok = !rst && state == RUN && bus.enable && !bus.rd_req_almostfull &&
                   bus.outstanding < 11'(MAX_OUT);
        bus.req0_ready = grant_ok && bus.req0_valid && (!bus.req1_valid || !ptr);
        bus.req1_ready = grant_ok && bus.req1_valid && (!bus.req0_valid || ptr);
        xfer0 = bus.req0_ready && bus.req0_valid;
        xfer1 = bus.req1_ready && bus.req1_valid;
        xfer = xfer0 || xfer1;
        // a response with nothing outstanding only flags tag_err, never underflows
        dec = bus.rd_rsp_valid && bus.outstanding != '0;
        out_nxt = bus.outstanding + 11'(xfer) - 11'(dec);
        state_nxt = (state != RUN && bus.enable) ? RUN :
                    (state == RUN && !bus.enable) ? DRAIN :
                    (state == DRAIN && out_nxt == '0) ? DRAINED : state;
        bus.drained = state == DRAINED;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            ptr              <= 1'b0;
            seq0             <= '0;
            seq1             <= '0;
            bus.rd_req_en    <= 1'b0;
            bus.rd_req_addr  <= '0;
            bus.rd_req_mdata <= '0;
            bus.rsp0_valid   <= 1'b0;
            bus.rsp1_valid   <= 1'b0;
            bus.rsp0_data    <= '0;
            bus.rsp1_data    <= '0;
            bus.outstanding  <= '0;
            bus.tag_err      <= 1'b0;
        end else begin
            state           <= state_nxt;
            bus.rd_req_en   <= xfer;
            bus.outstanding <= out_nxt;
            bus.tag_err     <= bus.tag_err || (bus.rd_rsp_valid && bus.outstanding == '0);
            bus.rsp0_valid  <= bus.rd_rsp_valid && !bus.rd_rsp_mdata[0];
            bus.rsp1_valid  <= bus.rd_rsp_valid && bus.rd_rsp_mdata[0];
            if (xfer) begin
                ptr              <= xfer0;
                bus.rd_req_addr  <= xfer1 ? bus.req1_addr : bus.req0_addr;
                bus.rd_req_mdata <= xfer1 ? {seq1, 1'b1} : {seq0, 1'b0};
            end
            if (xfer0)
                seq0 <= seq0 + 1'b1;
            if (xfer1)
                seq1 <= seq1 + 1'b1;
            if (bus.rd_rsp_valid && !bus.rd_rsp_mdata[0])
                bus.rsp0_data <= bus.rd_rsp_data;
            if (bus.rd_rsp_valid && bus.rd_rsp_mdata[0])
                bus.rsp1_data <= bus.rd_rsp_data;
        end
    end
endmodule
